// File: rtl/ls7402.sv
`default_nettype none
// ============================================================================
// Module      : ls7402
// Description : Parameterised quad-NOR glue primitive (74x02 style) with a
//               combinational result, an enable-gated registered copy and a
//               one-cycle change strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ls7402 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             chg
);

    logic [WIDTH-1:0] w_nor;
    logic [WIDTH-1:0] r_y_q;
    logic             r_chg;

    // Lanes are independent gates; a 1 on either input forces the lane low.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign w_nor[i] = ~(a[i] | b[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q <= '0;
            r_chg <= 1'b0;
        end else begin
            r_chg <= en && (w_nor != r_y_q);
            if (en) begin
                r_y_q <= w_nor;
            end
        end
    end

    assign y   = w_nor;
    assign y_q = r_y_q;
    assign chg = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_ls7402.sv
`default_nettype none
// ============================================================================
// Module      : tb_ls7402
// Description : Directed testbench for ls7402 at WIDTH 4, 1 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ls7402;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] a, b;
    logic [7:0] a8, b8;

    logic [3:0] y4, y_q4;
    logic       chg4;
    logic [0:0] y1, y_q1;
    logic       chg1;
    logic [7:0] y8, y_q8;
    logic       chg8;

    int vectors     = 0;
    int miscompares = 0;

    assign a8 = {b, a};
    assign b8 = {a, b};

    always #5 clk = ~clk;

    ls7402 #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
        .y(y4), .y_q(y_q4), .chg(chg4)
    );
    ls7402 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a[0:0]), .b(b[0:0]), .en(en),
        .y(y1), .y_q(y_q1), .chg(chg1)
    );
    ls7402 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .en(en),
        .y(y8), .y_q(y_q8), .chg(chg8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A lane output is 1 exactly when neither of its inputs is set.
    function automatic logic [31:0] nor_ref(input logic [31:0] x, input logic [31:0] z, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) begin
            if (x[i] === 1'b1 || z[i] === 1'b1) r[i] = 1'b0;
            else if (x[i] === 1'b0 && z[i] === 1'b0) r[i] = 1'b1;
            else r[i] = 1'bx;
        end
        return r;
    endfunction

    // Reference registers: last loaded value and whether this edge changed it.
    logic [31:0] m_q4 = '0, m_q1 = '0, m_q8 = '0;
    logic        m_c4 = 1'b0, m_c1 = 1'b0, m_c8 = 1'b0;

    always @(posedge clk) begin
        logic [31:0] n4, n1, n8;
        n4 = nor_ref({28'd0, a}, {28'd0, b}, 4);
        n1 = nor_ref({31'd0, a[0]}, {31'd0, b[0]}, 1);
        n8 = nor_ref({24'd0, a8}, {24'd0, b8}, 8);
        if (rst_n !== 1'b1) begin
            m_q4 = '0; m_q1 = '0; m_q8 = '0;
            m_c4 = 1'b0; m_c1 = 1'b0; m_c8 = 1'b0;
        end else if (en === 1'b1) begin
            m_c4 = (n4 != m_q4); m_q4 = n4;
            m_c1 = (n1 != m_q1); m_q1 = n1;
            m_c8 = (n8 != m_q8); m_q8 = n8;
        end else begin
            m_c4 = 1'b0; m_c1 = 1'b0; m_c8 = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("y4",    {28'd0, y4},   nor_ref({28'd0, a}, {28'd0, b}, 4));
        chk("y_q4",  {28'd0, y_q4}, m_q4);
        chk("chg4",  {31'd0, chg4}, {31'd0, m_c4});
        chk("y1",    {31'd0, y1},   nor_ref({31'd0, a[0]}, {31'd0, b[0]}, 1));
        chk("y_q1",  {31'd0, y_q1}, m_q1);
        chk("chg1",  {31'd0, chg1}, {31'd0, m_c1});
        chk("y8",    {24'd0, y8},   nor_ref({24'd0, a8}, {24'd0, b8}, 8));
        chk("y_q8",  {24'd0, y_q8}, m_q8);
        chk("chg8",  {31'd0, chg8}, {31'd0, m_c8});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [3:0] eq, input logic ec, input logic [3:0] ey);
        chk({name, ".y_q"}, {28'd0, y_q4}, {28'd0, eq});
        chk({name, ".chg"}, {31'd0, chg4}, {31'd0, ec});
        chk({name, ".y"},   {28'd0, y4},   {28'd0, ey});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1;
        a = 4'b0000; b = 4'b0011; #1;
        chk("comb0", {28'd0, y4}, 32'h0000000c);
        a = 4'b1010; b = 4'b0110; #1;
        chk("comb1", {28'd0, y4}, 32'h00000001);

        // Reset held for two edges with a=b=0
        a = 4'b0000; b = 4'b0000;
        tick(); tick();
        lit("reset", 4'b0000, 1'b0, 4'b1111);
        chk("reset.y_q1", {31'd0, y_q1}, 32'd0);
        chk("reset.y_q8", {24'd0, y_q8}, 32'd0);
        chk("reset.y8",   {24'd0, y8},   32'h000000ff);
        rst_n = 1'b1;
        tick();
        lit("first_load", 4'b1111, 1'b1, 4'b1111);
        tick();
        lit("steady", 4'b1111, 1'b0, 4'b1111);

        // Enable gating
        a = 4'b0000; b = 4'b0011;
        tick();
        lit("load_c", 4'b1100, 1'b1, 4'b1100);
        en = 1'b0; a = 4'b1010; b = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("hold", 4'b1100, 1'b0, 4'b0001);
        end
        en = 1'b1;
        tick();
        lit("reenable", 4'b0001, 1'b1, 4'b0001);
        tick();
        lit("reenable2", 4'b0001, 1'b0, 4'b0001);

        // Reset dominance mid-stream
        a = 4'b0101; b = 4'b0000;
        tick();
        lit("pre_rst", 4'b1010, 1'b1, 4'b1010);
        rst_n = 1'b0; a = 4'b0000; b = 4'b0100;
        tick();
        lit("mid_rst", 4'b0000, 1'b0, 4'b1011);
        rst_n = 1'b1; a = 4'b0001; b = 4'b0000;
        tick();
        lit("post_rst", 4'b1110, 1'b1, 4'b1110);

        // Exhaustive lane sweep with a varying enable pattern
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = i[7:0];
            a = v[7:4]; b = v[3:0];
            en = (i % 3) != 0;
            #1;
            chk("sweep.y", {28'd0, y4}, {28'd0, ~(v[7:4] | v[3:0])});
            tick();
        end
        a = 4'b1111; b = 4'b1111; #1;
        chk("all_ones.y", {28'd0, y4}, 32'd0);
        a = 4'b0000; b = 4'b0000; #1;
        chk("all_zero.y", {28'd0, y4}, 32'h0000000f);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
